bcdcount_multi: RTL and testbench

Parametrised, fully synchronous multi-digit BCD counter: N cascaded decades in one clock domain, with per-digit enable chaining in place of ripple clocks. Adds up/down counting, parallel load, a configurable most-significant-digit limit (e.g. 0–59 for clock/timer displays) and a registered wrap/boundary pulse for chaining further counters. It sits between tick generators and display/encoder logic in timer, clock and event-counter designs.

---
 rtl/bcdcount_pkg.sv | 8 +
 rtl/bcdcount_digit.sv | 30 +++
 rtl/bcdcount_multi.sv | 69 ++++++
 tb/tb_bcdcount_multi.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/bcdcount_pkg.sv
// Shared types and constants for the multi-digit BCD counter.
package bcdcount_pkg;
    localparam int DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] digit_t;

    localparam digit_t BCD_MAX = 4'd9;
endpackage

// File: rtl/bcdcount_digit.sv
// One BCD decade: sanitised load, up/down step with roll-over at 0 / limit.
module bcdcount_digit
    import bcdcount_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   step_in,
    input  logic   up,
    input  logic   load,
    input  digit_t load_digit,
    input  digit_t limit,
    output digit_t q,
    output logic   at_max,
    output logic   at_min
);
    assign at_max = (q == limit);
    assign at_min = (q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            // Out-of-range nibbles collapse to 0 so q never holds a bad digit
            q <= (load_digit > limit) ? '0 : load_digit;
        end else if (step_in) begin
            if (up) q <= at_max ? '0 : q + 4'd1;
            else    q <= at_min ? limit : q - 4'd1;
        end
    end
endmodule

// File: rtl/bcdcount_multi.sv
// Synchronous N-decade BCD up/down counter with load, MSD limit and carry pulse.
// Optional: define BCDCOUNT_SATURATE_EN to hold at the boundary instead of wrapping.
module bcdcount_multi
    import bcdcount_pkg::*;
#(
    parameter int DIGITS  = 3,
    parameter int MSD_MAX = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  carry
);
    logic [DIGITS-1:0][DIGIT_W-1:0] q;
    logic [DIGITS-1:0][DIGIT_W-1:0] ld;
    logic [DIGITS-1:0]              at_max;
    logic [DIGITS-1:0]              at_min;
    logic [DIGITS-1:0]              qual;
    logic [DIGITS-1:0]              step;
    logic                           boundary;
    logic                           go;

    assign ld       = load_val;
    assign count    = q;
    assign qual     = up ? at_max : at_min;
    assign boundary = &qual;

`ifdef BCDCOUNT_SATURATE_EN
    assign go = en & ~boundary;
`else
    assign go = en;
`endif

    genvar i;
    generate
        for (i = 0; i < DIGITS; i++) begin : g_digit
            localparam digit_t LIM = (i == DIGITS - 1) ? digit_t'(MSD_MAX) : BCD_MAX;

            // Digit i steps when every lower digit sits at its roll-over value
            if (i == 0) begin : g_lsd
                assign step[i] = go;
            end else begin : g_upper
                assign step[i] = go & (&qual[i-1:0]);
            end

            bcdcount_digit u_digit (
                .clk        (clk),
                .rst        (rst),
                .step_in    (step[i]),
                .up         (up),
                .load       (load),
                .load_digit (ld[i]),
                .limit      (LIM),
                .q          (q[i]),
                .at_max     (at_max[i]),
                .at_min     (at_min[i])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || load) carry <= 1'b0;
        else             carry <= en & boundary;
    end
endmodule

// File: tb/tb_bcdcount_multi.sv
// Randomised and directed checks of bcdcount_multi against an integer reference model.
module tb_bcdcount_multi;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1 = 1'b1, en1 = 1'b0, up1 = 1'b1, load1 = 1'b0;
    logic [11:0] lv1 = '0;
    logic [11:0] count1;
    logic        carry1;

    logic        rst2 = 1'b1, en2 = 1'b0, up2 = 1'b1, load2 = 1'b0;
    logic [7:0]  lv2 = '0;
    logic [7:0]  count2;
    logic        carry2;

    bcdcount_multi #(.DIGITS(3), .MSD_MAX(9)) dut (
        .clk(clk), .rst(rst1), .en(en1), .up(up1), .load(load1),
        .load_val(lv1), .count(count1), .carry(carry1)
    );

    bcdcount_multi #(.DIGITS(2), .MSD_MAX(5)) dut2 (
        .clk(clk), .rst(rst2), .en(en2), .up(up2), .load(load2),
        .load_val(lv2), .count(count2), .carry(carry2)
    );

    int   n_chk  = 0;
    int   n_fail = 0;
    int   m1 = 0, m2 = 0;
    logic c1 = 1'b0, c2 = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int pow10(input int n);
        int p = 1;
        for (int k = 0; k < n; k++) p *= 10;
        return p;
    endfunction

    function automatic int maxval(input int d, input int m);
        return m * pow10(d - 1) + pow10(d - 1) - 1;
    endfunction

    function automatic logic [31:0] to_bcd(input int v, input int d);
        logic [31:0] r = '0;
        for (int k = 0; k < d; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
        return r;
    endfunction

    function automatic int from_load(input logic [31:0] lv, input int d, input int m);
        int v = 0;
        for (int k = 0; k < d; k++) begin
            int nib = int'(lv[4*k +: 4]);
            int lim = (k == d - 1) ? m : 9;
            if (nib > lim) nib = 0;
            v += nib * pow10(k);
        end
        return v;
    endfunction

    task automatic mdl(inout int v, inout logic c, input logic r, input logic l,
                       input logic e, input logic u, input logic [31:0] lv,
                       input int d, input int m);
        int mx = maxval(d, m);
        if (r) begin
            v = 0; c = 1'b0;
        end else if (l) begin
            v = from_load(lv, d, m); c = 1'b0;
        end else if (e) begin
            if (u ? (v == mx) : (v == 0)) begin
                c = 1'b1;
`ifndef BCDCOUNT_SATURATE_EN
                v = u ? 0 : mx;
`endif
            end else begin
                c = 1'b0;
                v = u ? v + 1 : v - 1;
            end
        end else begin
            c = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        mdl(m1, c1, rst1, load1, en1, up1, 32'(lv1), 3, 9);
        mdl(m2, c2, rst2, load2, en2, up2, 32'(lv2), 2, 5);
        #1;
        chk("count1", 32'(count1), to_bcd(m1, 3));
        chk("carry1", 32'(carry1), 32'(c1));
        chk("count2", 32'(count2), to_bcd(m2, 2));
        chk("carry2", 32'(carry2), 32'(c2));
    endtask

    task automatic set1(input logic r, input logic l, input logic e, input logic u,
                        input logic [11:0] lv);
        rst1 = r; load1 = l; en1 = e; up1 = u; lv1 = lv;
    endtask

    task automatic set2(input logic r, input logic l, input logic e, input logic u,
                        input logic [7:0] lv);
        rst2 = r; load2 = l; en2 = e; up2 = u; lv2 = lv;
    endtask

    int pulses;

    initial begin
        tick();
        tick();
        chk("rst_count1", 32'(count1), 32'h0);
        chk("rst_carry1", 32'(carry1), 32'h0);
        set2(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);

        // Up 1000 from zero: exactly one carry pulse
        pulses = 0;
        set1(1'b0, 1'b0, 1'b1, 1'b1, 12'h000);
        for (int k = 0; k < 1000; k++) begin
            tick();
            if (carry1) pulses++;
        end
        tick();
        if (carry1) pulses++;
        chk("up_pulses", 32'(pulses), 32'd1);

        // Load 305 and count down 306
        set1(1'b0, 1'b1, 1'b0, 1'b0, 12'h305);
        tick();
        chk("load305", 32'(count1), 32'h305);
        pulses = 0;
        set1(1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
        for (int k = 0; k < 306; k++) begin
            tick();
            if (carry1) pulses++;
        end
        tick();
        if (carry1) pulses++;
        chk("down_pulses", 32'(pulses), 32'd1);

        // Invalid load with en high: sanitised, no carry
        set1(1'b0, 1'b1, 1'b1, 1'b1, 12'h9AF);
        tick();
        chk("load_inv", 32'(count1), 32'h900);
        chk("load_inv_c", 32'(carry1), 32'h0);

        // Boundary: up at 999 twice, then reset while enabled at 999
        set1(1'b0, 1'b1, 1'b0, 1'b1, 12'h999);
        tick();
        set1(1'b0, 1'b0, 1'b1, 1'b1, 12'h000);
        tick();
        tick();
        set1(1'b0, 1'b1, 1'b0, 1'b1, 12'h999);
        tick();
        set1(1'b1, 1'b0, 1'b1, 1'b1, 12'h000);
        tick();
        chk("rst_mid_count", 32'(count1), 32'h0);
        chk("rst_mid_carry", 32'(carry1), 32'h0);

        // Down at 000
        set1(1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
        tick();
        tick();
        set1(1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        tick();

        // MSD limit 5: 58 -> 59 -> 00 -> 01
        set2(1'b0, 1'b1, 1'b0, 1'b1, 8'h58);
        tick();
        set2(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        for (int k = 0; k < 3; k++) tick();
        set2(1'b0, 1'b1, 1'b0, 1'b1, 8'h7A);
        tick();
        chk("msd_inv_load", 32'(count2), 32'h00);

        // Randomised mix, biased towards boundary load values
        for (int k = 0; k < 600; k++) begin
            logic [11:0] r1;
            logic [7:0]  r2;
            case ($urandom_range(0, 3))
                0: r1 = 12'h999;
                1: r1 = 12'h000;
                default: r1 = 12'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0: r2 = 8'h59;
                1: r2 = 8'h00;
                default: r2 = 8'($urandom);
            endcase
            set1($urandom_range(0, 49) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 3) != 0, 1'($urandom), r1);
            set2($urandom_range(0, 49) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 3) != 0, 1'($urandom), r2);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
